nn_system_seq: RTL and testbench

- Parametrised successor of the three-layer spiking classifier top.
- A single tagged configuration port replaces the five per-parameter clock-enable strobes.
- Input frames arrive over a ready/valid stream into a shadow buffer.
- A run FSM clears membranes, steps the network for T_STEPS cycles, accumulates output spikes per class and reports the argmax class with a done pulse. Sits directly under the chip top; instantiates the existing layer block three times.

---
 rtl/nn_system_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_nn_system_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/nn_system_seq.sv
// rtl/nn_system_seq.sv - three-layer spiking classifier with streamed config, framed input and run FSM
module nn_cfg_sipo #(
    parameter int W  = 8,
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [PW-1:0] data,
    output logic [W-1:0]  sr,
    output logic          loaded
);
    localparam int BEATS = W / PW;
    localparam int CW    = $clog2(BEATS + 1);

    logic [CW-1:0] cnt;

    // Counter saturates at a full load; later beats still shift the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (en) begin
            sr <= {sr[W-PW-1:0], data};
            if (cnt != CW'(BEATS)) cnt <= cnt + 1'b1;
        end
    end

    assign loaded = (cnt == CW'(BEATS));
endmodule

module nn_layer #(
    parameter int N_I = 8,
    parameter int N_O = 4,
    parameter int SW  = 2,
    parameter int TW  = 8,
    parameter int FW  = 4,
    parameter int AW  = 8,
    parameter int VW  = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic [N_I-1:0]       s_in,
    input  logic [N_I*N_O-1:0]   w,
    input  logic [N_O*SW-1:0]    beta_shift,
    input  logic [N_O*TW-1:0]    minus_teta,
    input  logic [N_O*FW-1:0]    bn_factor,
    input  logic [N_O*AW-1:0]    bn_addend,
    output logic [N_O-1:0]       s_out
);
    for (genvar j = 0; j < N_O; j++) begin : g_neuron
        logic signed [VW-1:0] v, syn, fac, add, thr, sum, margin;
        logic spk;

        // Leaky integrate: v - v/2^beta + (popcount * factor + addend); fire when v + minus_teta >= 0.
        always_comb begin
            syn = '0;
            for (int i = 0; i < N_I; i++)
                syn = syn + VW'(s_in[i] & w[j*N_I + i]);
            fac    = VW'($signed({1'b0, bn_factor[j*FW +: FW]}));
            add    = VW'($signed(bn_addend[j*AW +: AW]));
            thr    = VW'($signed(minus_teta[j*TW +: TW]));
            sum    = v - (v >>> beta_shift[j*SW +: SW]) + syn * fac + add;
            margin = sum + thr;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v   <= '0;
                spk <= 1'b0;
            end else if (ce) begin
                spk <= !margin[VW-1];
                v   <= margin[VW-1] ? sum : '0;
            end
        end

        assign s_out[j] = spk;
    end
endmodule

module nn_system_seq #(
    parameter int N_IN    = 32,
    parameter int N_H0    = 4,
    parameter int N_H1    = 4,
    parameter int N_OUT   = 4,
    parameter int PW      = 2,
    parameter int IW      = 8,
    parameter int T_STEPS = 16,
    parameter int CNT_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PW-1:0]              cfg_data,
    input  logic [2:0]                 cfg_sel,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    output logic [4:0]                 cfg_loaded,
    input  logic [IW-1:0]              in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_OUT)-1:0]   class_out,
    output logic [N_OUT*CNT_W-1:0]     spike_counts
);
    localparam int SW       = 2;
    localparam int TW       = 8;
    localparam int FW       = 4;
    localparam int AW       = 8;
    localparam int NN       = N_H0 + N_H1 + N_OUT;
    // Output layer is wired one-to-one from H1, so only the two hidden matrices are loadable.
    localparam int W_W      = N_IN*N_H0 + N_H0*N_H1;
    localparam int CLS_W    = $clog2(N_OUT);
    localparam int IN_BEATS = N_IN / IW;
    localparam int IC_W     = $clog2(IN_BEATS + 1);
    localparam int O1       = N_H0;
    localparam int O2       = N_H0 + N_H1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DECIDE, S_DONE} state_t;
    state_t state, state_n;

    logic [W_W-1:0]   weights;
    logic [NN*SW-1:0] beta_shift;
    logic [NN*TW-1:0] minus_teta;
    logic [NN*FW-1:0] bn_factor;
    logic [NN*AW-1:0] bn_addend;
    logic             cfg_acc, accept, clear, layer_ce, layer_rst_n;

    assign cfg_ready = !busy;
    assign cfg_acc   = cfg_valid && cfg_ready;

    nn_cfg_sipo #(.W(W_W),   .PW(PW)) u_cfg_w  (.clk(clk), .rst_n(rst_n), .en(cfg_acc && cfg_sel == 3'd0), .data(cfg_data), .sr(weights),    .loaded(cfg_loaded[0]));
    nn_cfg_sipo #(.W(NN*SW), .PW(PW)) u_cfg_bs (.clk(clk), .rst_n(rst_n), .en(cfg_acc && cfg_sel == 3'd1), .data(cfg_data), .sr(beta_shift), .loaded(cfg_loaded[1]));
    nn_cfg_sipo #(.W(NN*TW), .PW(PW)) u_cfg_mt (.clk(clk), .rst_n(rst_n), .en(cfg_acc && cfg_sel == 3'd2), .data(cfg_data), .sr(minus_teta), .loaded(cfg_loaded[2]));
    nn_cfg_sipo #(.W(NN*FW), .PW(PW)) u_cfg_bf (.clk(clk), .rst_n(rst_n), .en(cfg_acc && cfg_sel == 3'd3), .data(cfg_data), .sr(bn_factor),  .loaded(cfg_loaded[3]));
    nn_cfg_sipo #(.W(NN*AW), .PW(PW)) u_cfg_ba (.clk(clk), .rst_n(rst_n), .en(cfg_acc && cfg_sel == 3'd4), .data(cfg_data), .sr(bn_addend),  .loaded(cfg_loaded[4]));

    logic [N_IN-1:0] shadow, x;
    logic [IC_W-1:0] in_cnt;
    logic            frame_full;

    assign in_ready = !frame_full;
    assign accept   = start && state == S_IDLE && frame_full && (&cfg_loaded);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            x          <= '0;
            in_cnt     <= '0;
            frame_full <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                shadow <= {shadow[N_IN-IW-1:0], in_data};
                if (in_cnt == IC_W'(IN_BEATS - 1)) begin
                    in_cnt     <= '0;
                    frame_full <= 1'b1;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end
            if (accept) begin
                x          <= shadow;
                frame_full <= 1'b0;
            end
        end
    end

    logic [7:0] step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (accept) state_n = S_CLEAR;
            S_CLEAR:  state_n = S_RUN;
            S_RUN:    if (step == 8'(T_STEPS - 1)) state_n = S_DECIDE;
            S_DECIDE: state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        clear    = (state == S_CLEAR);
        layer_ce = (state == S_RUN);
    end

    // Membranes are zeroed by pulsing the layers' reset for the single CLEAR cycle.
    assign layer_rst_n = rst_n & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              step <= '0;
        else if (accept)         step <= '0;
        else if (state == S_RUN) step <= step + 1'b1;
    end

    logic [N_H0-1:0]       h0_spk;
    logic [N_H1-1:0]       h1_spk;
    logic [N_OUT-1:0]      out_spk;
    logic [N_H1*N_OUT-1:0] w_out;

    always_comb begin
        w_out = '0;
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_H1; i++)
                if (i == j) w_out[j*N_H1 + i] = 1'b1;
    end

    nn_layer #(.N_I(N_IN), .N_O(N_H0), .SW(SW), .TW(TW), .FW(FW), .AW(AW)) u_l0 (
        .clk(clk), .rst_n(layer_rst_n), .ce(layer_ce), .s_in(x), .w(weights[N_IN*N_H0-1:0]),
        .beta_shift(beta_shift[0 +: N_H0*SW]), .minus_teta(minus_teta[0 +: N_H0*TW]),
        .bn_factor(bn_factor[0 +: N_H0*FW]), .bn_addend(bn_addend[0 +: N_H0*AW]), .s_out(h0_spk));

    nn_layer #(.N_I(N_H0), .N_O(N_H1), .SW(SW), .TW(TW), .FW(FW), .AW(AW)) u_l1 (
        .clk(clk), .rst_n(layer_rst_n), .ce(layer_ce), .s_in(h0_spk), .w(weights[W_W-1:N_IN*N_H0]),
        .beta_shift(beta_shift[O1*SW +: N_H1*SW]), .minus_teta(minus_teta[O1*TW +: N_H1*TW]),
        .bn_factor(bn_factor[O1*FW +: N_H1*FW]), .bn_addend(bn_addend[O1*AW +: N_H1*AW]), .s_out(h1_spk));

    nn_layer #(.N_I(N_H1), .N_O(N_OUT), .SW(SW), .TW(TW), .FW(FW), .AW(AW)) u_l2 (
        .clk(clk), .rst_n(layer_rst_n), .ce(layer_ce), .s_in(h1_spk), .w(w_out),
        .beta_shift(beta_shift[O2*SW +: N_OUT*SW]), .minus_teta(minus_teta[O2*TW +: N_OUT*TW]),
        .bn_factor(bn_factor[O2*FW +: N_OUT*FW]), .bn_addend(bn_addend[O2*AW +: N_OUT*AW]), .s_out(out_spk));

    logic [CNT_W-1:0] counts [N_OUT];
    logic [CNT_W-1:0] best_val;
    logic [CLS_W-1:0] best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) counts[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_OUT; i++) counts[i] <= '0;
        end else if (state == S_RUN) begin
            for (int i = 0; i < N_OUT; i++)
                if (out_spk[i] && counts[i] != '1) counts[i] <= counts[i] + 1'b1;
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_counts
        assign spike_counts[i*CNT_W +: CNT_W] = counts[i];
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = counts[0];
        for (int i = 1; i < N_OUT; i++)
            if (counts[i] > best_val) begin
                best_val = counts[i];
                best_idx = CLS_W'(i);
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 class_out <= '0;
        else if (state == S_DECIDE) class_out <= best_idx;
    end
endmodule

// File: tb/tb_nn_system_seq.sv
// tb/tb_nn_system_seq.sv - directed and table-driven checks for nn_system_seq
`timescale 1ns/1ps
module tb_nn_system_seq;
    localparam int WW = 144, BSW = 24, MTW = 96, BFW = 48, BAW = 96;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  cfg_data = '0;
    logic [2:0]  cfg_sel = '0;
    logic        cfg_valid = 1'b0, in_valid = 1'b0, start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        cfg_ready, in_ready, busy, done;
    logic [4:0]  cfg_loaded;
    logic [1:0]  class_out;
    logic [19:0] spike_counts;
    logic        cfg_ready_b, in_ready_b, busy_b, done_b;
    logic [4:0]  cfg_loaded_b;
    logic [1:0]  class_out_b;
    logic [19:0] spike_counts_b;

    nn_system_seq dut (
        .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_sel(cfg_sel), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_loaded(cfg_loaded), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .busy(busy), .done(done), .class_out(class_out),
        .spike_counts(spike_counts));

    nn_system_seq #(.T_STEPS(40), .CNT_W(5)) dut40 (
        .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_sel(cfg_sel), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready_b), .cfg_loaded(cfg_loaded_b), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .start(start), .busy(busy_b), .done(done_b), .class_out(class_out_b),
        .spike_counts(spike_counts_b));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, dcyc;

    typedef struct {
        logic [3:0]  mask;
        logic [1:0]  exp_class;
        logic [19:0] exp_counts;
    } vec_t;
    vec_t vecs [5];

    localparam logic [23:0] BS_VEC = 24'h555555;
    localparam logic [95:0] MT_VEC = 96'hFFFFFFFF_80808080_80808080;
    localparam logic [47:0] BF_VEC = 48'h111111111111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_beats(input logic [2:0] sel, input logic [1:0] d, input int n);
        for (int b = 0; b < n; b++) begin
            cfg_sel = sel; cfg_data = d; cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic load_vec(input logic [2:0] sel, input logic [143:0] vec, input int width);
        for (int b = 0; b < width / 2; b++) begin
            cfg_sel = sel; cfg_data = vec[width-1-2*b -: 2]; cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int b = 0; b < 4; b++) begin
            in_data = f[31-8*b -: 8]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_run(input bit use_b, input int bound, output int dc);
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        while (!(use_b ? done_b : done) && cyc < bound) tick();
        dc = cyc;
    endtask

    function automatic logic [95:0] ba_vec(input logic [3:0] m);
        ba_vec = '0;
        for (int n = 0; n < 4; n++)
            if (m[n]) ba_vec[(8+n)*8 +: 8] = 8'h7F;
    endfunction

    initial begin
        vecs[0] = '{4'b0000, 2'd0, 20'h00000};
        vecs[1] = '{4'b0010, 2'd1, 20'h001E0};
        vecs[2] = '{4'b1100, 2'd2, 20'h7BC00};
        vecs[3] = '{4'b1000, 2'd3, 20'h78000};
        vecs[4] = '{4'b0101, 2'd0, 20'h03C0F};

        tick(); tick(); rst_n = 1'b1; tick();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_cfg_loaded", cfg_loaded, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_class", class_out, 0);
        check("rst_counts", spike_counts, 0);

        send_beats(3'd0, 2'b00, 64);
        check("w64_loaded", cfg_loaded, 5'b00000);
        send_beats(3'd0, 2'b00, 7);
        check("w71_loaded", cfg_loaded, 5'b00000);
        send_beats(3'd0, 2'b00, 1);
        check("w72_loaded", cfg_loaded, 5'b00001);
        send_beats(3'd6, 2'b11, 3);
        check("rsvd_loaded", cfg_loaded, 5'b00001);
        check("rsvd_weights", (dut.u_cfg_w.sr == '0), 1);

        load_vec(3'd1, BS_VEC, BSW);
        load_vec(3'd2, MT_VEC, MTW);
        load_vec(3'd4, ba_vec(4'b0000), BAW);
        check("partial_loaded", cfg_loaded, 5'b10111);
        send_frame(32'hA1B2C3D4);
        check("frame_in_ready", in_ready, 0);
        check("shadow", dut.shadow, 32'hA1B2C3D4);
        start = 1'b1; tick(); start = 1'b0;
        check("gated_busy", busy, 0);
        tick();
        check("gated_busy2", busy, 0);
        check("gated_in_ready", in_ready, 0);

        load_vec(3'd3, BF_VEC, BFW);
        check("all_loaded", cfg_loaded, 5'b11111);
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        check("run_busy", busy, 1);
        check("run_in_ready", in_ready, 1);
        check("run_x", dut.x, 32'hA1B2C3D4);
        check("run_cfg_ready", cfg_ready, 0);
        send_frame(32'h11223344);
        while (!done && cyc < 40) tick();
        check("done_latency", cyc, 19);
        check("x_kept", dut.x, 32'hA1B2C3D4);
        check("new_frame_full", in_ready, 0);
        tick();
        check("done_width", done, 0);
        check("idle_busy", busy, 0);
        check("silent_counts", spike_counts, 0);
        check("silent_class", class_out, 0);

        for (int v = 0; v < 5; v++) begin
            load_vec(3'd4, ba_vec(vecs[v].mask), BAW);
            if (in_ready) send_frame(32'h0F0F0F0F);
            do_run(1'b0, 40, dcyc);
            check($sformatf("vec%0d_done", v), done, 1);
            tick();
            check($sformatf("vec%0d_class", v), class_out, vecs[v].exp_class);
            check($sformatf("vec%0d_counts", v), spike_counts, vecs[v].exp_counts);
        end

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("b_rst_loaded", cfg_loaded_b, 0);
        send_beats(3'd0, 2'b00, WW / 2);
        load_vec(3'd1, BS_VEC, BSW);
        load_vec(3'd2, MT_VEC, MTW);
        load_vec(3'd3, BF_VEC, BFW);
        load_vec(3'd4, ba_vec(4'b1100), BAW);
        check("b_loaded", cfg_loaded_b, 5'b11111);
        send_frame(32'h00000000);
        do_run(1'b1, 100, dcyc);
        check("b_done_latency", dcyc, 43);
        tick();
        check("b_sat_counts", spike_counts_b, 20'hFFC00);
        check("b_sat_class", class_out_b, 2);
        check("a_tie_counts", spike_counts, 20'h7BC00);
        check("a_tie_class", class_out, 2);

        send_frame(32'h12345678);
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        while (cyc < 10) tick();
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_loaded", cfg_loaded, 0);
        check("mid_rst_counts", spike_counts, 0);
        tick(); rst_n = 1'b1;
        send_frame(32'h12345678);
        start = 1'b1; tick(); start = 1'b0; tick();
        check("noreload_busy", busy, 0);
        check("noreload_in_ready", in_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
